// File: rtl/mem_access.sv
// MEM stage of the 5-stage MIPS pipeline: issues data-memory loads/stores on an
// SRAM-like req/addr_ok/data_ok bus and registers the bundle consumed by writeback.
module mem_access #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic [1:0]  mem_size,
    input  logic        mem_sign,
    input  logic [31:0] Aluout,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        wb_valid,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic [31:0] Aluout_out,
    output logic [31:0] rdata_out,
    output logic [4:0]  rd_out,
    output logic        exc_out,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      state;
    logic        lat_memtoreg;
    logic        lat_regwrite;
    logic        lat_sign;
    logic [4:0]  lat_rd;
    logic [31:0] wait_cnt;

    logic        mem_op;
    logic        misaligned;
    logic [3:0]  store_wstrb;
    logic [31:0] store_wdata;
    logic [31:0] load_data;

    assign in_ready = (state == S_IDLE);
    assign mem_op   = MemRead | MemWrite;

    // Size 2'b11 is not a legal encoding; it is treated like a word everywhere.
    assign misaligned = (mem_size == 2'b01 && Aluout[0]) ||
                        (mem_size[1] && Aluout[1:0] != 2'b00);

    always_comb begin
        store_wstrb = 4'b0000;
        store_wdata = wdata;
        if (MemWrite) begin
            case (mem_size)
                2'b00: begin
                    store_wstrb = 4'b0001 << Aluout[1:0];
                    store_wdata = {4{wdata[7:0]}};
                end
                2'b01: begin
                    store_wstrb = Aluout[1] ? 4'b1100 : 4'b0011;
                    store_wdata = {2{wdata[15:0]}};
                end
                default: store_wstrb = 4'b1111;
            endcase
        end
    end

    // Load extension works from the latched address/size, since rdata arrives later.
    always_comb begin
        logic [31:0] shifted;
        logic [15:0] half;
        shifted   = data_rdata >> {data_addr[1:0], 3'b000};
        half      = data_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
        load_data = data_rdata;
        case (data_size)
            2'b00:   load_data = {{24{lat_sign & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{16{lat_sign & half[15]}}, half};
            default: load_data = data_rdata;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            data_req     <= 1'b0;
            data_wr      <= 1'b0;
            data_size    <= 2'b00;
            data_addr    <= 32'h0;
            data_wstrb   <= 4'b0000;
            data_wdata   <= 32'h0;
            lat_memtoreg <= 1'b0;
            lat_regwrite <= 1'b0;
            lat_sign     <= 1'b0;
            lat_rd       <= 5'd0;
            wait_cnt     <= 32'd0;
            wb_valid     <= 1'b0;
            MemtoReg_out <= 1'b0;
            RegWrite_out <= 1'b0;
            Aluout_out   <= 32'h0;
            rdata_out    <= 32'h0;
            rd_out       <= 5'd0;
            exc_out      <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            exc_out  <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (!mem_op || misaligned) begin
                            // Non-memory ops and misaligned accesses retire without the bus.
                            wb_valid     <= 1'b1;
                            exc_out      <= mem_op;
                            MemtoReg_out <= MemtoReg;
                            RegWrite_out <= RegWrite & ~mem_op;
                            Aluout_out   <= Aluout;
                            rdata_out    <= 32'h0;
                            rd_out       <= rd;
                        end else begin
                            state        <= S_REQ;
                            data_req     <= 1'b1;
                            data_wr      <= MemWrite;
                            data_size    <= mem_size;
                            data_addr    <= Aluout;
                            data_wstrb   <= store_wstrb;
                            data_wdata   <= store_wdata;
                            lat_memtoreg <= MemtoReg;
                            lat_regwrite <= RegWrite;
                            lat_sign     <= mem_sign;
                            lat_rd       <= rd;
                        end
                    end
                end
                S_REQ: begin
                    if (data_addr_ok) begin
                        state    <= S_WAIT;
                        data_req <= 1'b0;
                        wait_cnt <= 32'd0;
                    end
                end
                S_WAIT: begin
                    if (data_data_ok) begin
                        state        <= S_IDLE;
                        wb_valid     <= 1'b1;
                        MemtoReg_out <= lat_memtoreg;
                        RegWrite_out <= lat_regwrite;
                        Aluout_out   <= data_addr;
                        rdata_out    <= data_wr ? 32'h0 : load_data;
                        rd_out       <= lat_rd;
                    end else if (TIMEOUT > 0 && wait_cnt == 32'(TIMEOUT - 1)) begin
                        state        <= S_IDLE;
                        wb_valid     <= 1'b1;
                        bus_err      <= 1'b1;
                        MemtoReg_out <= lat_memtoreg;
                        RegWrite_out <= 1'b0;
                        Aluout_out   <= data_addr;
                        rdata_out    <= 32'h0;
                        rd_out       <= lat_rd;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (TIMEOUT=4): ALU pass-through, loads with extension,
// stores with lane replication, misalignment, watchdog and reset abort.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        MemRead, MemWrite, MemtoReg, RegWrite;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [31:0] Aluout, wdata;
    logic [4:0]  rd;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        wb_valid, MemtoReg_out, RegWrite_out;
    logic [31:0] Aluout_out, rdata_out;
    logic [4:0]  rd_out;
    logic        exc_out, bus_err;

    int checks = 0;
    int errors = 0;

    mem_access #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .mem_size(mem_size), .mem_sign(mem_sign), .Aluout(Aluout), .wdata(wdata), .rd(rd),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .wb_valid(wb_valid),
        .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out), .Aluout_out(Aluout_out),
        .rdata_out(rdata_out), .rd_out(rd_out), .exc_out(exc_out), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
        mem_size = 2'b00; mem_sign = 1'b0; Aluout = 32'h0; wdata = 32'h0; rd = 5'd0;
    endtask

    // Presents one bundle for a single accepted cycle.
    task automatic issue(input logic mr, input logic mw, input logic rw, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] dst);
        in_valid = 1'b1; MemRead = mr; MemWrite = mw; MemtoReg = mr; RegWrite = rw;
        mem_size = sz; mem_sign = sg; Aluout = addr; wdata = wd; rd = dst;
        tick();
        clear_in();
    endtask

    task automatic run_load(input string tag, input logic [1:0] sz, input logic sg,
                            input logic [31:0] addr, input logic [31:0] raw,
                            input logic [31:0] exp);
        issue(1'b1, 1'b0, 1'b1, sz, sg, addr, 32'h0, 5'd7);
        check({tag, "_req"}, 32'(data_req), 32'd1);
        check({tag, "_wstrb"}, 32'(data_wstrb), 32'd0);
        check({tag, "_addr"}, data_addr, addr);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        check({tag, "_req_drop"}, 32'(data_req), 32'd0);
        data_data_ok = 1'b1; data_rdata = raw;
        tick();
        data_data_ok = 1'b0;
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd1);
        check({tag, "_rdata"}, rdata_out, exp);
        check({tag, "_rd"}, 32'(rd_out), 32'd7);
        tick();
        check({tag, "_wb_pulse"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
        clear_in();
        reset = 1'b1; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        tick(); tick();
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_data_req", 32'(data_req), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_aluout", Aluout_out, 32'h0);

        // ALU op: latency 1, then outputs hold
        issue(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h1234, 32'h0, 5'd5);
        check("alu_wb_valid", 32'(wb_valid), 32'd1);
        check("alu_aluout", Aluout_out, 32'h1234);
        check("alu_rd", 32'(rd_out), 32'd5);
        check("alu_regwrite", 32'(RegWrite_out), 32'd1);
        check("alu_exc", 32'(exc_out), 32'd0);
        tick();
        check("alu_pulse", 32'(wb_valid), 32'd0);
        check("alu_hold", Aluout_out, 32'h1234);

        run_load("lb", 2'b00, 1'b1, 32'h103, 32'h80FF_0000, 32'hFFFF_FF80);
        run_load("lbu", 2'b00, 1'b0, 32'h103, 32'h80FF_0000, 32'h0000_0080);
        run_load("lh", 2'b01, 1'b1, 32'h102, 32'h8001_1234, 32'hFFFF_8001);
        run_load("lhu", 2'b01, 1'b0, 32'h100, 32'h8001_9234, 32'h0000_9234);
        run_load("lw", 2'b10, 1'b0, 32'h104, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // sh with addr_ok held off for 3 cycles
        issue(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0000_ABCD, 5'd0);
        check("sh_req", 32'(data_req), 32'd1);
        check("sh_wr", 32'(data_wr), 32'd1);
        check("sh_wstrb", 32'(data_wstrb), 32'hC);
        check("sh_wdata", data_wdata, 32'hABCD_ABCD);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sh_stall_ready", 32'(in_ready), 32'd0);
            check("sh_stall_req", 32'(data_req), 32'd1);
        end
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        check("sh_wait_ready", 32'(in_ready), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
        tick();
        data_data_ok = 1'b0;
        check("sh_wb_valid", 32'(wb_valid), 32'd1);
        check("sh_rdata", rdata_out, 32'h0);
        check("sh_regwrite", 32'(RegWrite_out), 32'd0);

        // sb lane 1
        issue(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 32'h101, 32'h1234_5677, 5'd0);
        check("sb_wstrb", 32'(data_wstrb), 32'h2);
        check("sb_wdata", data_wdata, 32'h7777_7777);
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; tick(); data_data_ok = 1'b0;
        check("sb_wb_valid", 32'(wb_valid), 32'd1);

        // misaligned lw
        issue(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h101, 32'h0, 5'd9);
        check("mis_req", 32'(data_req), 32'd0);
        check("mis_wb_valid", 32'(wb_valid), 32'd1);
        check("mis_exc", 32'(exc_out), 32'd1);
        check("mis_regwrite", 32'(RegWrite_out), 32'd0);
        check("mis_ready", 32'(in_ready), 32'd1);
        tick();
        check("mis_exc_pulse", 32'(exc_out), 32'd0);

        // watchdog: 4 WAIT cycles without data_ok
        issue(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h200, 32'h0, 5'd3);
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        tick(); tick(); tick();
        check("wd_w4_ready", 32'(in_ready), 32'd0);
        check("wd_w4_valid", 32'(wb_valid), 32'd0);
        tick();
        check("wd_wb_valid", 32'(wb_valid), 32'd1);
        check("wd_bus_err", 32'(bus_err), 32'd1);
        check("wd_regwrite", 32'(RegWrite_out), 32'd0);
        check("wd_ready", 32'(in_ready), 32'd1);
        data_data_ok = 1'b1; tick(); data_data_ok = 1'b0;
        check("wd_late_ok", 32'(wb_valid), 32'd0);
        check("wd_late_err", 32'(bus_err), 32'd0);

        // reset in WAIT, then stale data_ok
        issue(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h300, 32'h0, 5'd4);
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        check("rw_ready", 32'(in_ready), 32'd1);
        check("rw_req", 32'(data_req), 32'd0);
        check("rw_aluout", Aluout_out, 32'h0);
        check("rw_rd", 32'(rd_out), 32'd0);
        data_data_ok = 1'b1; data_rdata = 32'h1111_1111; tick(); data_data_ok = 1'b0;
        check("rw_stale_ok", 32'(wb_valid), 32'd0);
        tick();
        check("rw_quiet", 32'(wb_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
